// File: rtl/nand_share_pkg.sv
// nand_share_pkg
// Shared types and default constants for the NAND-sharing arbiter.
//   state_t   : response-stage state (EMPTY = no result held, FULL = result held)
//   NREQ_DEF  : default number of requesters
//   CNTW_DEF  : default width of the completed-operation counter
package nand_share_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int CNTW_DEF = 16;

endpackage

// File: rtl/nandGate.sv
// nandGate
// The single physical NAND resource being shared.
//   i1, i2 : operands
//   o      : ~(i1 & i2)
module nandGate (
  input  logic i1,
  input  logic i2,
  output logic o
);

  assign o = ~(i1 & i2);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Pointer-based round-robin pick: chooses the first asserted request at or
// after ptr, wrapping modulo N. The pointer register lives in the parent.
//   req     : request vector
//   ptr     : search start index (0..N-1)
//   en      : when 0, gnt is forced to zero (pick is still computed)
//   gnt     : one-hot grant (or zero)
//   gnt_idx : binary index of the picked request (meaningful when any=1)
//   any     : at least one request is asserted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [IW:0] w_sum;
  logic        w_found;

  assign any = |req;

  // Walk offsets 0..N-1 from ptr; the first hit wins. Since ptr < N and the
  // offset < N, a single conditional subtract implements the wrap.
  always_comb begin
    w_found = 1'b0;
    gnt_idx = '0;
    w_sum   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        gnt_idx = w_sum[IW-1:0];
      end
    end
  end

  // Decode the winning index back to one-hot, gated by enable.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = en & any & (gnt_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter
// Time-multiplexes one nandGate among NREQ requesters. A round-robin pick
// grants one valid request per cycle; its NAND result is captured into a
// single-entry response register tagged with the winner's ID.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_a/b    : per-requester operand bits (bit i belongs to requester i)
//   req_ready  : one-hot (or zero) combinational accept
//   rsp_valid  : response register holds a result
//   rsp_ready  : consumer accepts the response this cycle
//   rsp_id     : index of the requester that produced rsp_data
//   rsp_data   : NAND of the granted operands
//   op_count   : saturating count of completed response handshakes
module nand_share_arbiter
  import nand_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_data,
  output logic [CNTW-1:0] op_count
);

  state_t          r_state;
  state_t          w_state_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_data;
  logic [CNTW-1:0] r_op_count;

  logic            w_can_accept;
  logic            w_arb_en;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_nand_i1;
  logic            w_nand_i2;
  logic            w_nand_o;

  // Pipelined accept: a draining response frees the slot in the same cycle.
  assign w_can_accept = (r_state == EMPTY) | rsp_ready;
  // Reset masks all grants so no request handshake can complete during rst.
  assign w_arb_en     = w_can_accept & ~rst;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready  = w_gnt;
  // The grant is only ever given to a valid requester, so enable & any is
  // exactly "some request handshake fires this cycle".
  assign w_req_fire = w_arb_en & w_any;
  assign w_rsp_fire = (r_state == FULL) & rsp_ready;

  // Operands are steered only on a real handshake; otherwise held at 0 so the
  // shared gate sees quiet inputs while idle or backpressured.
  assign w_nand_i1 = w_req_fire ? req_a[w_gnt_idx] : 1'b0;
  assign w_nand_i2 = w_req_fire ? req_b[w_gnt_idx] : 1'b0;

  nandGate u_nand (
    .i1 (w_nand_i1),
    .i2 (w_nand_i2),
    .o  (w_nand_o)
  );

  // Response-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-derived outputs. A new grant wins over a drain so
  // back-to-back operation keeps the stage FULL.
  always_comb begin
    w_state_next = r_state;
    rsp_valid    = 1'b0;
    case (r_state)
      EMPTY: begin
        rsp_valid = 1'b0;
        if (w_req_fire) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        rsp_valid = 1'b1;
        if (w_req_fire) begin
          w_state_next = FULL;
        end else if (w_rsp_fire) begin
          w_state_next = EMPTY;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  // Response payload and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_id   <= '0;
      r_rsp_data <= 1'b0;
      r_ptr      <= '0;
    end else if (w_req_fire) begin
      r_rsp_id   <= w_gnt_idx;
      r_rsp_data <= w_nand_o;
      // Explicit wrap keeps the pointer in range for non power-of-two NREQ.
      if (w_gnt_idx == IDW'(NREQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_gnt_idx + IDW'(1);
      end
    end
  end

  // Saturating completed-operation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_fire && (r_op_count != {CNTW{1'b1}})) begin
      r_op_count <= r_op_count + CNTW'(1);
    end
  end

  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_nand_share_arbiter.sv
module tb_nand_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_a, req_b, req_ready;
  logic        rsp_valid, rsp_ready, rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  // Second instance with a 3-bit counter for the saturation check.
  logic        s_rst;
  logic [3:0]  s_valid, s_a, s_b, s_req_ready;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_data;
  logic [1:0]  s_rsp_id;
  logic [2:0]  s_op_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nand_share_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .op_count(op_count)
  );

  nand_share_arbiter #(.NREQ(4), .IDW(2), .CNTW(3)) dut_sat (
    .clk(clk), .rst(s_rst), .req_valid(s_valid), .req_a(s_a), .req_b(s_b),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .op_count(s_op_count)
  );

  // Reference model: a held result slot, a round-robin start index and a
  // completion tally, advanced once per clock from the rules of operation.
  logic        m_full;
  int          m_id;
  logic        m_data;
  int          m_ptr;
  int          m_count;
  logic [3:0]  m_last_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic rdy, input logic r);
    logic [3:0] g;
    g = 4'b0000;
    if (!r && !(m_full && !rdy)) begin
      for (int k = 0; k < 4; k++) begin
        if (g == 4'b0000 && v[(m_ptr + k) % 4]) g[(m_ptr + k) % 4] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [3:0] a, input logic [3:0] b,
                              input logic rdy, input logic r, input logic [3:0] g);
    if (r) begin
      m_full = 1'b0; m_id = 0; m_data = 1'b0; m_ptr = 0; m_count = 0;
    end else begin
      if (m_full && rdy && m_count < 65535) m_count++;
      if (g != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (g[i]) begin
            m_id   = i;
            m_data = ~(a[i] & b[i]);
            m_ptr  = (i + 1) % 4;
          end
        end
        m_full = 1'b1;
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check the combinational grant, then check
  // the registered outputs just after the rising edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic rdy, input logic r);
    logic [3:0] eg;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rdy; rst = r;
    #1;
    eg = model_grant(v, rdy, r);
    m_last_gnt = eg;
    chk("req_ready", 32'(req_ready), 32'(eg));
    @(posedge clk);
    model_update(a, b, rdy, r, eg);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("op_count", 32'(op_count), 32'(m_count));
  endtask

  logic [3:0] h_v, h_a, h_b;

  initial begin
    m_full = 1'b0; m_id = 0; m_data = 1'b0; m_ptr = 0; m_count = 0; m_last_gnt = '0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; rst = 1'b1;
    s_rst = 1'b1; s_valid = '0; s_a = '0; s_b = '0; s_rsp_ready = 1'b0;

    // Reset, then a single request from requester 0 with a=b=1.
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // All operand pairs on requester 2, back to back.
    for (int p = 0; p < 4; p++) begin
      cycle(4'b0100, {1'b0, p[1], 2'b00}, {1'b0, p[0], 2'b00}, 1'b1, 1'b0);
    end
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Round-robin with every requester asserting.
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) cycle(4'b1111, 4'b1010, 4'b0110, 1'b1, 1'b0);

    // Backpressure while holding requester 1's result.
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) cycle(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);

    // Reset with a held result and five completions.
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) cycle(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Randomized traffic: requesters hold their operands until granted.
    h_v = '0; h_a = '0; h_b = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!h_v[i] && $urandom_range(0, 1) == 1) begin
          h_v[i] = 1'b1;
          h_a[i] = 1'($urandom_range(0, 1));
          h_b[i] = 1'($urandom_range(0, 1));
        end
      end
      cycle(h_v, h_a, h_b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      h_v = h_v & ~m_last_gnt;
    end

    // Counter saturation on the 3-bit instance: requester 0 always valid,
    // consumer always ready; edge e completes e-1 operations.
    @(negedge clk);
    s_rst = 1'b0; s_valid = 4'b0001; s_a = 4'b0001; s_b = 4'b0000; s_rsp_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      chk("sat_op_count", 32'(s_op_count), 32'((e - 1 < 7) ? e - 1 : 7));
    end
    chk("sat_rsp_data", 32'(s_rsp_data), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
